ex_ls_pipe_reg: RTL and testbench
=================================

Name: ex_ls_pipe_reg

Overview:
Pipeline register between the execute stage and the load/store stage. It captures one execute result bundle per valid/ready handshake and presents it to the LSU. It is a 2-entry skid buffer, so `in_ready` is a registered signal and never depends combinationally on `out_ready`. Full throughput is kept: 1 beat/cycle when the LSU is always ready. A synchronous flush discards in-flight bundles on redirect.

Parameters:
XLEN, 64, data path width (pc, alures, wdata)
CTRL_W, 18, packed control width: {wflag, rflag, csrflag, jalrflag, ecallflag, mretflag, ebreak, abort, func3[2:0], func7[6:0]}

Ports:
clock  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
flush  in  1  discard all held bundles (synchronous)
in_valid  in  1  execute result valid
in_ready  out  1  buffer can accept (registered)
in_pc  in  XLEN  instruction pc
in_inst  in  32  instruction word
in_alures  in  XLEN  ALU / mul-div result (already masked)
in_wdata  in  XLEN  store data (rs2)
in_wmask  in  8  store byte mask
in_waddr  in  5  rd address
in_wen  in  1  register write enable
in_ctrl  in  CTRL_W  packed control flags
out_valid  out  1  bundle valid to LSU
out_ready  in  1  LSU accepts
out_pc, out_inst, out_alures, out_wdata, out_wmask, out_waddr, out_wen, out_ctrl  out  (widths as in_*)  head bundle

Behaviour:
- Storage:
  - Main entry M drives the `out_*` signals.
  - Skid entry S is used only when M is stalled.
  - Payload is registered only; no combinational in→out path for data or valid.
- State machine (2-bit `state`):
  - EMPTY: M and S invalid.
  - BUSY: M valid, S invalid.
  - FULL: M and S valid.
- Outputs:
  - `out_valid = (state != EMPTY)`.
  - `in_ready = (state != FULL)`, registered.
- Events: `push = in_valid & in_ready`; `pop = out_valid & out_ready`.
- Transitions:
  - EMPTY + push → BUSY; M ← in.
  - BUSY + push & !pop → FULL; S ← in.
  - BUSY + push & pop → BUSY; M ← in (back-to-back streaming).
  - BUSY + !push & pop → EMPTY.
  - FULL + pop → BUSY; M ← S. No push is possible in FULL.
  - Otherwise hold.
- Bundle latency: 1 cycle from push to `out_valid` when the buffer is EMPTY.
- Ordering: strictly FIFO. No bundle is ever duplicated or dropped except by flush.
- Payload regs while not valid: hold their last value (not cleared), except `out_wen`.
  - `out_wen` is forced to 0 when the entry is invalid, so a stale register write can never leak.
- Flush:
  - Next state EMPTY, regardless of push/pop in the same cycle; flush wins.
  - `in_ready` = 1 the cycle after flush.
  - A push presented during the flush cycle is discarded.
- Reset (also mid-operation): state EMPTY, `out_valid` = 0, `in_ready` = 1, `out_wen` = 0, all payload regs = 0.
- `out_ready` asserted while `out_valid` = 0 has no effect.
- `in_valid` may drop without a handshake (the upstream mul/div busy case). No state change results.

Optional Feature:
Macro EXLS_PERF_CNT_EN.
- Defined: adds output `perf_stall_cnt` [63:0].
  - Increments every cycle `out_valid & !out_ready`.
  - Cleared by reset only (not by flush).
  - Wraps at 2^64.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then `out_ready`=1 and 4 consecutive pushes with pc = 0x80000000, +4, +8, +C → `out_pc` shows the same sequence on cycles 1–4 after each push, `in_ready` stays 1, no bubbles.
- Single push (alures = 0x1234) with `out_ready`=0 for 3 cycles, second push (alures = 0x5678) → state FULL, `in_ready`=0 from the next cycle, `out_alures` holds 0x1234. Raise `out_ready`: 0x1234, then 0x5678 on consecutive cycles, then `out_valid`=0.
- FULL state + flush with `in_valid`=1 → next cycle `out_valid`=0, `out_wen`=0, `in_ready`=1. The pushed bundle never appears.
- Push with `in_wen`=1, `in_waddr`=5, then pop → after the pop `out_wen`=0 while `out_waddr` still reads 5.
- Reset asserted while FULL → next cycle `out_valid`=0, `in_ready`=1, all `out_*`=0.
- With EXLS_PERF_CNT_EN: hold `out_valid`=1, `out_ready`=0 for 7 cycles → `perf_stall_cnt` = 7. Flush → still 7.

Source files
------------

// File: rtl/ex_ls_pipe_reg.sv
// Execute -> load/store pipeline register: 2-entry skid buffer, 1-cycle latency, registered in_ready.
// Optional EXLS_PERF_CNT_EN adds perf_stall_cnt (cycles with out_valid & !out_ready).
module ex_ls_pipe_reg #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_alures,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [7:0]        in_wmask,
  input  logic [4:0]        in_waddr,
  input  logic              in_wen,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_inst,
  output logic [XLEN-1:0]   out_alures,
  output logic [XLEN-1:0]   out_wdata,
  output logic [7:0]        out_wmask,
  output logic [4:0]        out_waddr,
  output logic              out_wen,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef EXLS_PERF_CNT_EN
  ,
  output logic [63:0]       perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic [XLEN-1:0]   alures;
    logic [XLEN-1:0]   wdata;
    logic [7:0]        wmask;
    logic [4:0]        waddr;
    logic              wen;
    logic [CTRL_W-1:0] ctrl;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e  state_q, state_d;
  bundle_t m_q, m_d;
  bundle_t s_q, s_d;
  logic    in_ready_q, in_ready_d;
  logic    out_valid_q, out_valid_d;
  bundle_t in_b;
  logic    push;
  logic    pop;

  assign in_b = '{pc: in_pc, inst: in_inst, alures: in_alures, wdata: in_wdata,
                  wmask: in_wmask, waddr: in_waddr, wen: in_wen, ctrl: in_ctrl};

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = BUSY;
          m_d     = in_b;
        end
      end
      BUSY: begin
        if (push && pop) begin
          m_d = in_b;
        end else if (push) begin
          state_d = FULL;
          s_d     = in_b;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = BUSY;
          m_d     = s_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides everything; payload keeps its old contents so a discarded push leaves no trace.
    if (flush) begin
      state_d = EMPTY;
      m_d     = m_q;
      s_d     = s_q;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = m_q.pc;
  assign out_inst   = m_q.inst;
  assign out_alures = m_q.alures;
  assign out_wdata  = m_q.wdata;
  assign out_wmask  = m_q.wmask;
  assign out_waddr  = m_q.waddr;
  // A stale entry must never produce a register write.
  assign out_wen    = m_q.wen & out_valid_q;
  assign out_ctrl   = m_q.ctrl;

`ifdef EXLS_PERF_CNT_EN
  logic [63:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready) begin
      stall_cnt_d = stall_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_ls_pipe_reg.sv
// Bench for ex_ls_pipe_reg: directed vector table, perf counter sequence, then random traffic vs a queue model.
module tb_ex_ls_pipe_reg;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_alures = '0;
  logic [63:0] in_wdata = '0;
  logic [7:0]  in_wmask = '0;
  logic [4:0]  in_waddr = '0;
  logic        in_wen = 1'b0;
  logic [17:0] in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [63:0] out_alures;
  logic [63:0] out_wdata;
  logic [7:0]  out_wmask;
  logic [4:0]  out_waddr;
  logic        out_wen;
  logic [17:0] out_ctrl;
`ifdef EXLS_PERF_CNT_EN
  logic [63:0] perf_stall_cnt;
`endif

  ex_ls_pipe_reg #(.XLEN(64), .CTRL_W(18)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_alures(in_alures), .in_wdata(in_wdata),
    .in_wmask(in_wmask), .in_waddr(in_waddr), .in_wen(in_wen), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_alures(out_alures), .out_wdata(out_wdata),
    .out_wmask(out_wmask), .out_waddr(out_waddr), .out_wen(out_wen), .out_ctrl(out_ctrl)
`ifdef EXLS_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] alures;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [4:0]  waddr;
    logic        wen;
    logic [17:0] ctrl;
  } tb_b_t;

  typedef struct {
    bit          rst, fl, iv, ordy;
    logic [63:0] pc, alu;
    logic        wen;
    logic [4:0]  wa;
    bit          e_ov, e_ir;
    logic [63:0] e_pc, e_alu;
    logic        e_wen;
    logic [4:0]  e_wa;
    bit          e_zero;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [255:0] pay_out();
    return {1'b0, out_pc, out_inst, out_alures, out_wdata, out_wmask, out_waddr, out_ctrl};
  endfunction

  function automatic logic [255:0] pay_of(tb_b_t b);
    return {1'b0, b.pc, b.inst, b.alures, b.wdata, b.wmask, b.waddr, b.ctrl};
  endfunction

  task automatic drive(bit rst, bit fl, bit iv, bit ordy, tb_b_t b);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_pc     = b.pc;
    in_inst   = b.inst;
    in_alures = b.alures;
    in_wdata  = b.wdata;
    in_wmask  = b.wmask;
    in_waddr  = b.waddr;
    in_wen    = b.wen;
    in_ctrl   = b.ctrl;
  endtask

  function automatic tb_b_t mk(logic [63:0] pc, logic [63:0] alu, logic wen, logic [4:0] wa);
    tb_b_t b;
    b.pc = pc; b.alures = alu; b.wen = wen; b.waddr = wa;
    b.inst = pc[31:0] ^ 32'h13; b.wdata = alu ^ 64'hFFFF; b.wmask = alu[7:0] | 8'h1; b.ctrl = pc[17:0] ^ 18'h5;
    return b;
  endfunction

  task automatic v(bit rst, bit fl, bit iv, bit ordy, logic [63:0] pc, logic [63:0] alu, logic wen,
                   logic [4:0] wa, bit e_ov, bit e_ir, logic [63:0] e_pc, logic [63:0] e_alu,
                   logic e_wen, logic [4:0] e_wa, bit e_zero);
    vec_t t;
    t.rst = rst; t.fl = fl; t.iv = iv; t.ordy = ordy; t.pc = pc; t.alu = alu; t.wen = wen; t.wa = wa;
    t.e_ov = e_ov; t.e_ir = e_ir; t.e_pc = e_pc; t.e_alu = e_alu; t.e_wen = e_wen; t.e_wa = e_wa;
    t.e_zero = e_zero;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference model state: a FIFO of at most two bundles plus the last head shown.
  tb_b_t           mq[$];
  tb_b_t           last_head;
  longint unsigned exp_cnt;

  initial begin
    tb_b_t b;
    tb_b_t zero_b;
    zero_b = mk(64'd0, 64'd0, 1'b0, 5'd0);
    zero_b.inst = '0; zero_b.wdata = '0; zero_b.wmask = '0; zero_b.ctrl = '0;

    //  rst fl iv ordy pc              alu          wen wa    ov ir  e_pc            e_alu        wen wa   zero
    v(1, 0, 0, 0, 64'h0,        64'h0,    0, 5'd0,  0, 1, 64'h0,        64'h0,    0, 5'd0,  1);
    v(0, 0, 1, 1, 64'h80000000, 64'h1,    1, 5'd1,  1, 1, 64'h80000000, 64'h1,    1, 5'd1,  0);
    v(0, 0, 1, 1, 64'h80000004, 64'h2,    1, 5'd2,  1, 1, 64'h80000004, 64'h2,    1, 5'd2,  0);
    v(0, 0, 1, 1, 64'h80000008, 64'h3,    1, 5'd3,  1, 1, 64'h80000008, 64'h3,    1, 5'd3,  0);
    v(0, 0, 1, 1, 64'h8000000C, 64'h4,    1, 5'd4,  1, 1, 64'h8000000C, 64'h4,    1, 5'd4,  0);
    v(0, 0, 0, 1, 64'h0,        64'h0,    0, 5'd0,  0, 1, 64'h8000000C, 64'h4,    0, 5'd4,  0);
    v(0, 0, 1, 0, 64'h100,      64'h1234, 1, 5'd7,  1, 1, 64'h100,      64'h1234, 1, 5'd7,  0);
    v(0, 0, 0, 0, 64'h0,        64'h0,    0, 5'd0,  1, 1, 64'h100,      64'h1234, 1, 5'd7,  0);
    v(0, 0, 0, 0, 64'h0,        64'h0,    0, 5'd0,  1, 1, 64'h100,      64'h1234, 1, 5'd7,  0);
    v(0, 0, 1, 0, 64'h104,      64'h5678, 1, 5'd8,  1, 0, 64'h100,      64'h1234, 1, 5'd7,  0);
    v(0, 0, 1, 0, 64'h108,      64'h9999, 1, 5'd9,  1, 0, 64'h100,      64'h1234, 1, 5'd7,  0);
    v(0, 0, 0, 1, 64'h0,        64'h0,    0, 5'd0,  1, 1, 64'h104,      64'h5678, 1, 5'd8,  0);
    v(0, 0, 0, 1, 64'h0,        64'h0,    0, 5'd0,  0, 1, 64'h104,      64'h5678, 0, 5'd8,  0);
    v(0, 0, 1, 0, 64'h200,      64'hA,    1, 5'd9,  1, 1, 64'h200,      64'hA,    1, 5'd9,  0);
    v(0, 0, 1, 0, 64'h204,      64'hB,    1, 5'd10, 1, 0, 64'h200,      64'hA,    1, 5'd9,  0);
    v(0, 1, 1, 1, 64'h208,      64'hC,    1, 5'd11, 0, 1, 64'h200,      64'hA,    0, 5'd9,  0);
    v(0, 0, 0, 1, 64'h0,        64'h0,    0, 5'd0,  0, 1, 64'h200,      64'hA,    0, 5'd9,  0);
    v(0, 1, 1, 1, 64'h300,      64'hD,    1, 5'd12, 0, 1, 64'h200,      64'hA,    0, 5'd9,  0);
    v(0, 0, 0, 0, 64'h0,        64'h0,    0, 5'd0,  0, 1, 64'h200,      64'hA,    0, 5'd9,  0);
    v(0, 0, 1, 0, 64'h400,      64'hE,    1, 5'd5,  1, 1, 64'h400,      64'hE,    1, 5'd5,  0);
    v(0, 0, 0, 1, 64'h0,        64'h0,    0, 5'd0,  0, 1, 64'h400,      64'hE,    0, 5'd5,  0);
    v(0, 0, 0, 1, 64'h0,        64'h0,    0, 5'd0,  0, 1, 64'h400,      64'hE,    0, 5'd5,  0);
    v(0, 0, 1, 0, 64'h500,      64'hF,    1, 5'd11, 1, 1, 64'h500,      64'hF,    1, 5'd11, 0);
    v(0, 0, 1, 0, 64'h504,      64'h10,   1, 5'd12, 1, 0, 64'h500,      64'hF,    1, 5'd11, 0);
    v(1, 0, 1, 1, 64'h508,      64'h11,   1, 5'd13, 0, 1, 64'h0,        64'h0,    0, 5'd0,  1);
    v(0, 0, 0, 0, 64'h0,        64'h0,    0, 5'd0,  0, 1, 64'h0,        64'h0,    0, 5'd0,  1);

    @(negedge clock);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy,
            mk(vecs[i].pc, vecs[i].alu, vecs[i].wen, vecs[i].wa));
      step();
      chk($sformatf("v%0d out_valid", i), 256'(out_valid), 256'(vecs[i].e_ov));
      chk($sformatf("v%0d in_ready", i), 256'(in_ready), 256'(vecs[i].e_ir));
      chk($sformatf("v%0d out_pc", i), 256'(out_pc), 256'(vecs[i].e_pc));
      chk($sformatf("v%0d out_alures", i), 256'(out_alures), 256'(vecs[i].e_alu));
      chk($sformatf("v%0d out_wen", i), 256'(out_wen), 256'(vecs[i].e_wen));
      chk($sformatf("v%0d out_waddr", i), 256'(out_waddr), 256'(vecs[i].e_wa));
      if (vecs[i].e_zero) chk($sformatf("v%0d payload zero", i), pay_out(), 256'(0));
    end

`ifdef EXLS_PERF_CNT_EN
    drive(1, 0, 0, 0, zero_b); step();
    chk("perf reset", 256'(perf_stall_cnt), 256'(0));
    drive(0, 0, 1, 0, mk(64'h600, 64'h1, 1, 5'd1)); step();
    drive(0, 0, 0, 0, zero_b);
    for (int k = 0; k < 7; k++) step();
    chk("perf stall 7", 256'(perf_stall_cnt), 256'(7));
    drive(0, 1, 0, 1, zero_b); step();
    chk("perf after flush", 256'(perf_stall_cnt), 256'(7));
    chk("perf flush empties", 256'(out_valid), 256'(0));
    drive(0, 0, 0, 0, zero_b); step();
    chk("perf idle", 256'(perf_stall_cnt), 256'(7));
`endif

    // Random traffic against the FIFO model, starting from reset.
    for (int c = 0; c < 1500; c++) begin
      bit rst, fl, iv, ordy, do_pop, do_push;
      rst  = (c == 0) || ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 99) < 4);
      iv   = ($urandom_range(0, 99) < 65);
      ordy = ($urandom_range(0, 99) < 55);
      b.pc = {$urandom, $urandom}; b.inst = $urandom; b.alures = {$urandom, $urandom};
      b.wdata = {$urandom, $urandom}; b.wmask = 8'($urandom); b.waddr = 5'($urandom);
      b.wen = 1'($urandom); b.ctrl = 18'($urandom);
      drive(rst, fl, iv, ordy, b);
      if (rst) begin
        mq.delete();
        last_head = zero_b;
        exp_cnt   = 0;
      end else begin
        if (mq.size() > 0 && !ordy) exp_cnt++;
        if (fl) begin
          mq.delete();
        end else begin
          do_pop  = (mq.size() > 0) && ordy;
          do_push = iv && (mq.size() < 2);
          if (do_pop) void'(mq.pop_front());
          if (do_push) mq.push_back(b);
        end
        if (mq.size() > 0) last_head = mq[0];
      end
      step();
      chk("rand out_valid", 256'(out_valid), 256'(mq.size() > 0));
      chk("rand in_ready", 256'(in_ready), 256'(mq.size() < 2));
      chk("rand payload", pay_out(), pay_of(last_head));
      chk("rand out_wen", 256'(out_wen), 256'((mq.size() > 0) && last_head.wen));
`ifdef EXLS_PERF_CNT_EN
      chk("rand perf", 256'(perf_stall_cnt), 256'(exp_cnt));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
